wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Round-robin arbiter that shares one Wishbone slave among `NM` Wishbone masters, typically several AHB-to-Wishbone bridge instances. It grants exactly one master at a time. While a master holds the grant, the arbiter muxes that master's address, data and control onto the slave port and routes the slave's ack and read data back to it. An optional watchdog ends cycles the slave never acknowledges, so a dead slave cannot hang the shared bus.

## Interface
Parameters:
- `NM`, 4 — number of masters, 2..8
- `AWIDTH`, 16 — address width
- `DWIDTH`, 32 — data width
- `TIMEOUT`, 255 — watchdog limit in cycles, 1..65535; used only with the watchdog compiled in

Ports:
- `clk_i` in 1 — single clock
- `rst_i` in 1 — reset, synchronous, active-high
- `m_cyc_i` in NM — per-master bus-cycle request
- `m_stb_i` in NM — per-master strobe
- `m_we_i` in NM — per-master write enable
- `m_adr_i` in NM*AWIDTH — master addresses; master i occupies bits [i*AWIDTH +: AWIDTH]
- `m_dat_i` in NM*DWIDTH — master write data, packed the same way
- `m_dat_o` out DWIDTH — read data, broadcast to all masters
- `m_ack_o` out NM — per-master ack
- `m_err_o` out NM — per-master error (watchdog)
- `gnt_o` out NM — one-hot grant, registered
- `cyc_o`, `stb_o`, `we_o` out 1 — slave control
- `adr_o` out AWIDTH — slave address
- `dat_o` out DWIDTH — slave write data
- `dat_i` in DWIDTH — slave read data
- `ack_i` in 1 — slave ack

## Operation
- States: IDLE, OWN.
- Internal registers: `last` (index of the previous owner), `owner`, and the watchdog counter `wd_cnt`.
- **Reset:**
  - State goes to IDLE; `gnt_o` = 0.
  - `last` = NM-1, so master 0 has top priority after reset.
  - `wd_cnt` = 0.
  - All slave outputs and `m_ack_o`/`m_err_o` are 0 while in reset.
- **Reset mid-cycle:** the grant is dropped immediately. The slave sees `cyc_o` = 0 in the cycle after reset is sampled.
- **IDLE:**
  - If any `m_cyc_i` bit is set, select the first requester scanning upward from `last+1`, modulo NM.
  - Go to OWN with `owner` = selected index, `last` = selected index, and `gnt_o` = one-hot of `owner`.
  - If no request is present, stay in IDLE.
- **OWN:**
  - `cyc_o`/`stb_o`/`we_o`/`adr_o`/`dat_o` are driven combinationally from the owner's inputs.
  - `m_ack_o[owner]` = `ack_i`; `m_dat_o` = `dat_i`.
  - All other masters see ack = 0 and err = 0.
- **Release:** when `m_cyc_i[owner]` is sampled low, go to IDLE and clear `gnt_o`. There is always one IDLE cycle between owners.
- **Outside OWN:** all slave outputs are 0, `m_dat_o` is 0, and `ack_i` is ignored.
- **Multi-beat:** the owner keeps the grant for any number of strobes while its `cyc` stays high; the arbiter does not preempt.
- **Same-edge ack and cyc drop:** if `ack_i` and the owner's `cyc` drop on the same edge, the ack is delivered and the arbiter releases normally.
- **Non-owner requests:** requests that arrive or drop while another master owns the bus have no effect until IDLE.

## Timing
- Grant latency: `m_cyc_i[i]` high at edge E with the arbiter in IDLE gives `gnt_o[i]` = 1 and `cyc_o` = 1 after E. This is 1 cycle.
- Ack path is combinational, zero cycles: `ack_i` → `m_ack_o`.
- The slave-side mux is combinational from `gnt_o`; there are no extra pipeline stages.
- Release: the owner's `cyc` low at edge E gives `gnt_o` = 0 after E. The earliest next grant is after E+1.
- Under continuous requests from all masters, grant order is 0,1,2,…,NM-1,0. Each owner holds the bus for its own cycle plus one IDLE cycle.

## Configuration
- Macro: `WB_RR_ARBITER_WATCHDOG_EN`.
- **Defined:**
  - `wd_cnt` counts OWN cycles in which `stb_o`=1 and `ack_i`=0. It clears on ack, on `stb_o`=0, and on entry to OWN.
  - When `wd_cnt` == TIMEOUT-1 with no ack in that cycle, the arbiter pulses `m_err_o[owner]` for 1 cycle, forces `cyc_o`/`stb_o` = 0 in the following cycle, and goes to IDLE.
  - `last` keeps the timed-out index, so that master has the lowest priority in the next arbitration.
  - An ack arriving on the timeout cycle wins: ack is delivered and no err is raised.
- **Undefined:** no counter is built, `m_err_o` is tied to 0, and a missing ack holds the grant indefinitely.

## Structure
- Package `wb_arb_pkg`:
  - state encoding: IDLE=0, OWN=1
  - function `clog2` for owner/counter widths
  - default constants for NM, AWIDTH, DWIDTH, TIMEOUT
- Sub-module `wb_rr_pick`:
  - combinational rotating-priority encoder
  - inputs: request vector and `last`
  - outputs: `valid` and selected index
- All sequential logic stays in `wb_rr_arbiter`.

## Test plan
- Single request, NM=4: `m_cyc_i`=0010 at edge 3 → `gnt_o`=0010 after edge 3. A write to `adr` 0x1234 with data 0xDEADBEEF appears on the slave port. `ack_i` produces `m_ack_o`=0010 in the same cycle. Dropping `cyc` gives `gnt_o`=0 one edge later.
- Fairness: all four `m_cyc_i` held high, each master releasing after 1 ack → grant sequence 0,1,2,3,0 with exactly one IDLE cycle between grants.
- Isolation: master 2 owns the bus and master 0 raises `cyc` → master 0 sees no ack and `adr_o` stays at master 2's value. Master 0 is granted after master 2 releases and 1 IDLE cycle passes.
- Reset mid-cycle: `rst_i` asserted while master 1 owns the bus with `stb` high → `cyc_o`=0 and `gnt_o`=0 after that edge. The first grant after reset goes to master 0 when masters 0 and 3 request together.
- Watchdog (macro defined, TIMEOUT=8): master 3 strobes and the slave never acks → `m_err_o`=1000 for 1 cycle on the 8th stalled cycle, then the arbiter returns to IDLE. With masters 3 and 0 then both requesting, master 0 is granted first.
- Watchdog boundary: `ack_i` arrives exactly on the 8th stalled cycle → ack is delivered, `m_err_o` stays 0, and the grant is held.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Holds the state encoding, default parameters and a width helper.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int NM_DEF      = 4;
  localparam int AWIDTH_DEF  = 16;
  localparam int DWIDTH_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority encoder: first set request at or above last+1,
// wrapping modulo NM.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter  int NM = NM_DEF,
  localparam int IW = clog2(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] j;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int k = NM; k >= 1; k--) begin
      j = IW'((int'(last_i) + k) % NM);
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NM masters.
// Define WB_RR_ARBITER_WATCHDOG_EN to build the no-ack watchdog.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM      = NM_DEF,
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AWIDTH-1:0] m_adr_i,
  input  logic [NM*DWIDTH-1:0] m_dat_i,
  output logic [DWIDTH-1:0]    m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [NM-1:0]        gnt_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [AWIDTH-1:0]    adr_o,
  output logic [DWIDTH-1:0]    dat_o,
  input  logic [DWIDTH-1:0]    dat_i,
  input  logic                 ack_i
);

  localparam int IW = clog2(NM);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          own;
  logic          timeout;

  wb_rr_pick #(.NM(NM)) u_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Reset blanks the slave port at once, ahead of the state register.
  assign own   = (state_q == OWN) && !rst_i;
  assign gnt_o = gnt_q;

  always_comb begin
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    we_o    = 1'b0;
    adr_o   = '0;
    dat_o   = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (own) begin
      cyc_o            = m_cyc_i[owner_q];
      stb_o            = m_stb_i[owner_q];
      we_o             = m_we_i[owner_q];
      adr_o            = m_adr_i[int'(owner_q)*AWIDTH +: AWIDTH];
      dat_o            = m_dat_i[int'(owner_q)*DWIDTH +: DWIDTH];
      m_dat_o          = dat_i;
      m_ack_o[owner_q] = ack_i;
      m_err_o[owner_q] = timeout;
    end
  end

`ifdef WB_RR_ARBITER_WATCHDOG_EN
  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          stall;

  // An ack on the limit cycle clears stall, so the ack wins.
  assign stall    = own && stb_o && !ack_i;
  assign timeout  = stall && (wd_cnt_q == WD_LAST);
  assign wd_cnt_d = (stall && !timeout) ? wd_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          owner_d = pick_idx;
          last_d  = pick_idx;
          gnt_d   = NM'(1) << pick_idx;
        end
      end
      OWN: begin
        if (!m_cyc_i[owner_q] || timeout) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NM - 1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic
// against a queue-free behavioural scheduler model.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int OW = NM + 3 + AW + DW + DW + NM + NM;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, gnt_o;
  logic             cyc_o, stb_o, we_o;
  logic [AW-1:0]    adr_o;
  logic [DW-1:0]    dat_o, dat_i;
  logic             ack_i;

  int checks = 0;
  int passed = 0;

  int md_owner = -1;
  int md_last  = NM - 1;
  int md_wd    = 0;

  always #5 clk_i = ~clk_i;

  wb_rr_arbiter #(
    .NM(NM), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .gnt_o(gnt_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  function automatic logic md_timeout();
    if (!WD || rst_i || md_owner < 0) return 1'b0;
    return m_stb_i[md_owner] && !ack_i && (md_wd == TO - 1);
  endfunction

  function automatic logic [OW-1:0] md_expect();
    logic [NM-1:0] g, a, e;
    logic          c, s, w;
    logic [AW-1:0] ad;
    logic [DW-1:0] d, rd;
    g = '0; a = '0; e = '0;
    c = 0; s = 0; w = 0;
    ad = '0; d = '0; rd = '0;
    if (md_owner >= 0) g[md_owner] = 1'b1;
    if (md_owner >= 0 && !rst_i) begin
      c  = m_cyc_i[md_owner];
      s  = m_stb_i[md_owner];
      w  = m_we_i[md_owner];
      ad = m_adr_i[md_owner*AW +: AW];
      d  = m_dat_i[md_owner*DW +: DW];
      rd = dat_i;
      a[md_owner] = ack_i;
      e[md_owner] = md_timeout();
    end
    return {g, c, s, w, ad, d, rd, a, e};
  endfunction

  function automatic void md_tick();
    logic to;
    int   i;
    to = md_timeout();
    if (rst_i) begin
      md_owner = -1;
      md_last  = NM - 1;
      md_wd    = 0;
    end else if (md_owner < 0) begin
      md_wd = 0;
      for (int k = 1; k <= NM; k++) begin
        i = (md_last + k) % NM;
        if (m_cyc_i[i]) begin
          md_owner = i;
          md_last  = i;
          break;
        end
      end
    end else begin
      if (m_stb_i[md_owner] && !ack_i) md_wd++;
      else md_wd = 0;
      if (!m_cyc_i[md_owner] || to) begin
        md_owner = -1;
        md_wd    = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    md_tick();
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0;
    dat_i = '0; ack_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ack_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== '0) $display("FAIL reset_gnt: got %b expected 0", gnt_o);
    else passed++;
    checks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0) $display("FAIL reset_cyc: got %b%b expected 00", cyc_o, stb_o);
    else passed++;
    checks++;
    if (m_ack_o !== '0 || m_err_o !== '0) $display("FAIL reset_ack: got %b/%b expected 0/0", m_ack_o, m_err_o);
    else passed++;
    ack_i = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010; m_we_i = 4'b0010;
    m_adr_i[1*AW +: AW] = 16'h1234;
    m_dat_i[1*DW +: DW] = 32'hDEADBEEF;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0000) $display("FAIL single_latency: got %b expected 0000", gnt_o);
    else passed++;
    tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0010) $display("FAIL single_gnt: got %b expected 0010", gnt_o);
    else passed++;
    checks++;
    if ({cyc_o, stb_o, we_o} !== 3'b111) $display("FAIL single_ctl: got %b expected 111", {cyc_o, stb_o, we_o});
    else passed++;
    checks++;
    if (adr_o !== 16'h1234 || dat_o !== 32'hDEADBEEF) $display("FAIL single_port: got %h/%h expected 1234/deadbeef", adr_o, dat_o);
    else passed++;
    ack_i = 1'b1;
    dat_i = 32'hCAFE0001;
    #1;
    checks++;
    if (m_ack_o !== 4'b0010) $display("FAIL single_ack: got %b expected 0010", m_ack_o);
    else passed++;
    checks++;
    if (m_dat_o !== 32'hCAFE0001) $display("FAIL single_rdata: got %h expected cafe0001", m_dat_o);
    else passed++;
    tick();
    m_cyc_i = '0; m_stb_i = '0; ack_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0010) $display("FAIL single_hold: got %b expected 0010", gnt_o);
    else passed++;
    tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0000 || cyc_o !== 1'b0) $display("FAIL single_release: got %b/%b expected 0000/0", gnt_o, cyc_o);
    else passed++;
  endtask

  task automatic test_fairness();
    int seq[$];
    int idle;
    int idx;
    int want[5];
    logic [NM-1:0] g;
    want = '{0, 1, 2, 3, 0};
    idle = 0;
    do_reset();
    m_cyc_i = 4'b1111; m_stb_i = 4'b1111;
    for (int c = 0; c < 40 && seq.size() < 5; c++) begin
      @(negedge clk_i);
      g = gnt_o;
      if (g != '0) begin
        idx = -1;
        for (int b = 0; b < NM; b++) if (g[b]) idx = b;
        if (seq.size() > 0) begin
          checks++;
          if (idle !== 1) $display("FAIL fair_gap: got %0d idle cycles expected 1", idle);
          else passed++;
        end
        seq.push_back(idx);
        idle = 0;
      end else if (seq.size() > 0) begin
        idle++;
      end
      ack_i = (g != '0);
      m_cyc_i = 4'b1111 & ~g;
      m_stb_i = 4'b1111 & ~g;
      tick();
    end
    checks++;
    if (seq.size() != 5) $display("FAIL fair_count: got %0d grants expected 5", seq.size());
    else passed++;
    for (int k = 0; k < seq.size(); k++) begin
      checks++;
      if (seq[k] != want[k]) $display("FAIL fair_order: grant %0d got %0d expected %0d", k, seq[k], want[k]);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_isolation();
    do_reset();
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    m_adr_i[2*AW +: AW] = 16'hA2A2;
    tick();
    m_cyc_i = 4'b0101; m_stb_i = 4'b0101;
    m_adr_i[0*AW +: AW] = 16'h0F0F;
    ack_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (m_ack_o !== 4'b0100) $display("FAIL iso_ack: got %b expected 0100", m_ack_o);
    else passed++;
    checks++;
    if (adr_o !== 16'hA2A2 || gnt_o !== 4'b0100) $display("FAIL iso_port: got %h/%b expected a2a2/0100", adr_o, gnt_o);
    else passed++;
    tick();
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001; ack_i = 1'b0;
    tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0000) $display("FAIL iso_idle: got %b expected 0000", gnt_o);
    else passed++;
    tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0001) $display("FAIL iso_next: got %b expected 0001", gnt_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
    tick();
    @(negedge clk_i);
    checks++;
    if (cyc_o !== 1'b1 || gnt_o !== 4'b0010) $display("FAIL rmid_own: got %b/%b expected 1/0010", cyc_o, gnt_o);
    else passed++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_cyc_i = 4'b1001; m_stb_i = 4'b1001;
    @(negedge clk_i);
    checks++;
    if (cyc_o !== 1'b0 || gnt_o !== 4'b0000) $display("FAIL rmid_drop: got %b/%b expected 0/0000", cyc_o, gnt_o);
    else passed++;
    tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0001) $display("FAIL rmid_first: got %b expected 0001", gnt_o);
    else passed++;
  endtask

`ifdef WB_RR_ARBITER_WATCHDOG_EN
  task automatic test_watchdog();
    logic [NM-1:0] want;
    do_reset();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    tick();
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk_i);
      want = (n == TO) ? 4'b1000 : 4'b0000;
      checks++;
      if (m_err_o !== want) $display("FAIL wd_err: stall %0d got %b expected %b", n, m_err_o, want);
      else passed++;
      tick();
    end
    m_cyc_i = 4'b1001; m_stb_i = 4'b1001;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0000 || cyc_o !== 1'b0) $display("FAIL wd_idle: got %b/%b expected 0000/0", gnt_o, cyc_o);
    else passed++;
    tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0001) $display("FAIL wd_next: got %b expected 0001", gnt_o);
    else passed++;
  endtask

  task automatic test_watchdog_edge();
    do_reset();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    tick();
    for (int n = 1; n <= TO; n++) begin
      ack_i = (n == TO);
      @(negedge clk_i);
      checks++;
      if (m_err_o !== 4'b0000) $display("FAIL wdb_err: stall %0d got %b expected 0000", n, m_err_o);
      else passed++;
      if (n == TO) begin
        checks++;
        if (m_ack_o !== 4'b1000) $display("FAIL wdb_ack: got %b expected 1000", m_ack_o);
        else passed++;
      end
      tick();
    end
    ack_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b1000) $display("FAIL wdb_hold: got %b expected 1000", gnt_o);
    else passed++;
  endtask
`else
  task automatic test_no_watchdog();
    do_reset();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    for (int n = 0; n < 3 * TO; n++) tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b1000 || m_err_o !== 4'b0000) $display("FAIL nowd_hold: got %b/%b expected 1000/0000", gnt_o, m_err_o);
    else passed++;
  endtask
`endif

  task automatic test_random();
    logic [OW-1:0] exp_v, got_v;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_i = ($urandom_range(0, 59) == 0);
      for (int b = 0; b < NM; b++)
        if ($urandom_range(0, 3) == 0) m_cyc_i[b] = ~m_cyc_i[b];
      m_stb_i = NM'($urandom);
      m_we_i  = NM'($urandom);
      m_adr_i = {$urandom, $urandom};
      m_dat_i = {$urandom, $urandom, $urandom, $urandom};
      dat_i   = $urandom;
      ack_i   = ($urandom_range(0, 3) == 0);
      @(negedge clk_i);
      exp_v = md_expect();
      got_v = {gnt_o, cyc_o, stb_o, we_o, adr_o, dat_o, m_dat_o, m_ack_o, m_err_o};
      checks++;
      if (got_v !== exp_v) $display("FAIL rand_cycle %0d: got %h expected %h", c, got_v, exp_v);
      else passed++;
      tick();
    end
    rst_i = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_isolation();
    test_reset_mid();
`ifdef WB_RR_ARBITER_WATCHDOG_EN
    test_watchdog();
    test_watchdog_edge();
`else
    test_no_watchdog();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
